// File: rtl/dct_mac_array_unit.sv
// -----------------------------------------------------------------------------
// dct_mac_array_unit
//
// Streaming DCT multiply-accumulate result unit. Signed sample/coefficient
// pairs are multiplied in a registered product stage, TAPS products are summed
// per block, and each completed sum is rounded (half toward +inf),
// arithmetic-shifted right by SHIFT and saturated to OUT_W bits.
//
// A valid/ready handshake on both sides lets the downstream stall the whole
// pipeline: while a result is waiting and not accepted, every register holds.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   in_valid    sample/coefficient pair valid
//   in_ready    unit can accept a pair this cycle
//   in_data     signed sample, DATA_W bits
//   in_coef     signed coefficient, COEF_W bits
//   out_valid   result valid, held until accepted
//   out_ready   downstream accepts result
//   out_result  signed rounded/saturated coefficient, OUT_W bits
//   out_sat     out_result was clipped (qualified by out_valid)
// -----------------------------------------------------------------------------
module dct_mac_array_unit #(
    parameter  int DATA_W = 8,
    parameter  int COEF_W = 12,
    parameter  int TAPS   = 8,
    parameter  int SHIFT  = 11,
    parameter  int OUT_W  = 10,
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [COEF_W-1:0] in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_result,
    output logic                     out_sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TAPS);
    // One guard bit above the accumulator so the rounding constant can never
    // wrap the sum.
    localparam int RND_W  = ACC_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

    localparam logic signed [RND_W-1:0] ROUND_K =
        {{(RND_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [RND_W-1:0] OUT_MAX =
        {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] OUT_MIN =
        {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic signed [PROD_W-1:0] p_q,          p_d;
    logic                     p_v_q,        p_v_d;
    logic signed [ACC_W-1:0]  acc_q,        acc_d;
    logic        [CNT_W-1:0]  cnt_q,        cnt_d;
    logic                     out_valid_q,  out_valid_d;
    logic signed [OUT_W-1:0]  out_result_q, out_result_d;
    logic                     out_sat_q,    out_sat_d;

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic stall;
    logic accept;
    logic advance;
    logic complete;

    assign stall    = out_valid_q & ~out_ready;
    assign accept   = in_valid & ~stall;
    assign advance  = p_v_q & ~stall;
    assign complete = advance & (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Datapath: accumulate, round, shift, saturate
    // -------------------------------------------------------------------------
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [RND_W-1:0] rounded;
    logic signed [RND_W-1:0] shifted;
    logic signed [OUT_W-1:0] clip_res;
    logic                    clip_sat;

    assign p_ext = {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};

    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        clip_res = '0;
        clip_sat = 1'b0;

        // Tap 0 restarts the block instead of adding to the previous sum.
        acc_base = (cnt_q == '0) ? '0 : acc_q;
        acc_sum  = acc_base + p_ext;
        rounded  = {acc_sum[ACC_W-1], acc_sum} + ROUND_K;
        shifted  = rounded >>> SHIFT;

        if (shifted > OUT_MAX) begin
            clip_res = OUT_MAX[OUT_W-1:0];
            clip_sat = 1'b1;
        end else if (shifted < OUT_MIN) begin
            clip_res = OUT_MIN[OUT_W-1:0];
            clip_sat = 1'b1;
        end else begin
            clip_res = shifted[OUT_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic; holding under stall falls out of the defaults.
    // -------------------------------------------------------------------------
    always_comb begin
        p_d          = p_q;
        p_v_d        = p_v_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_sat_d    = out_sat_q;

        // The product register only loads on an accepted pair, so idle or
        // undriven input buses never reach the accumulator.
        if (!stall) begin
            p_v_d = accept;
            if (accept) begin
                p_d = in_data * in_coef;
            end
        end

        if (advance) begin
            acc_d = acc_sum;
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        // A completion in the same cycle as a handshake replaces the result
        // and keeps out_valid high, so nothing is dropped or repeated.
        if (complete) begin
            out_valid_d  = 1'b1;
            out_result_d = clip_res;
            out_sat_d    = clip_sat;
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q          <= '0;
            p_v_q        <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            p_q          <= p_d;
            p_v_q        <= p_v_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign in_ready   = ~stall;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_dct_mac_array_unit.sv
// -----------------------------------------------------------------------------
// tb_dct_mac_array_unit
//
// Self-checking bench for dct_mac_array_unit with default parameters.
// Expected results are computed from the driven pairs and queued when the
// last pair of a block is accepted; a monitor pops and compares on every
// output handshake.
// -----------------------------------------------------------------------------
module tb_dct_mac_array_unit;

    localparam int DATA_W = 8;
    localparam int COEF_W = 12;
    localparam int TAPS   = 8;
    localparam int SHIFT  = 11;
    localparam int OUT_W  = 10;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [COEF_W-1:0] in_coef;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_result;
    logic                     out_sat;

    typedef struct {
        longint res;
        longint sat;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks   = 0;
    int     errors   = 0;
    int     hs_cnt   = 0;
    int     hs0      = 0;
    longint blk_sum  = 0;
    int     blk_cnt  = 0;
    bit     toggle_en = 1'b0;

    dct_mac_array_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_coef    (in_coef),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input longint s);
        exp_t   e;
        longint r;
        longint hi;
        longint lo;
        hi    = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo    = -(longint'(1) <<< (OUT_W - 1));
        r     = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        e.sat = 0;
        if (r > hi) begin
            r     = hi;
            e.sat = 1;
        end else if (r < lo) begin
            r     = lo;
            e.sat = 1;
        end
        e.res = r;
        return e;
    endfunction

    // Drive one pair, hold it until accepted (bounded), update the model.
    // Called and returns at 1 time unit after a rising edge.
    task automatic send_pair(input int d, input int c);
        int waited   = 0;
        bit accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        in_coef  = COEF_W'(c);
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else          waited++;
        end
        check("accept", longint'(accepted), 1);
        if (accepted) begin
            blk_sum += longint'(d) * longint'(c);
            blk_cnt++;
            if (blk_cnt == TAPS) begin
                exp_q.push_back(model(blk_sum));
                blk_sum = 0;
                blk_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int d, input int c);
        repeat (TAPS) send_pair(d, c);
    endtask

    // Idle cycles with garbage on the data buses.
    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
            in_coef  = COEF_W'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", longint'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a handshake at the coming edge is visible at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                hs_cnt++;
                check("out_expected_pending", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("result", longint'(out_result), mon_e.res);
                    check("sat", longint'(out_sat), mon_e.sat);
                end
            end
        end
    end

    // Random backpressure, enabled only during the streaming test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_coef   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_result", longint'(out_result), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // 1: basic block, result 64, latency two cycles after last accept
        send_block(16, 1024);
        @(negedge clk);
        check("lat_not_yet_valid", longint'(out_valid), 0);
        @(negedge clk);
        check("lat_valid", longint'(out_valid), 1);
        check("lat_result", longint'(out_result), 64);
        wait_drain();

        // 2: rounding half toward +inf, back-to-back blocks
        send_block(1, 128);
        send_block(-1, 128);
        wait_drain();

        // 3: saturation both ways
        send_block(127, 2047);
        send_block(-128, 2047);
        wait_drain();

        // 4: backpressure with input still offered
        hs0       = hs_cnt;
        out_ready = 1'b0;
        send_block(16, 1024);
        fork
            send_block(1, 128);
        join_none
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("bp_valid_seen", longint'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready_low", longint'(in_ready), 0);
            check("bp_valid_held", longint'(out_valid), 1);
            check("bp_result_held", longint'(out_result), 64);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        wait_drain();
        check("bp_handshakes", longint'(hs_cnt - hs0), 2);

        // 5: reset mid-block discards the partial sum
        send_pair(5, 100);
        send_pair(5, 100);
        send_pair(5, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        blk_sum = 0;
        blk_cnt = 0;
        @(negedge clk);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        send_block(16, 1024);
        wait_drain();

        // 6: random stream with input gaps and toggling out_ready
        hs0       = hs_cnt;
        toggle_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int t = 0; t < TAPS; t++) begin
                idle(int'($urandom_range(0, 2)));
                send_pair(int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 4095)) - 2048);
            end
        end
        toggle_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
        check("stream_handshakes", longint'(hs_cnt - hs0), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
